// File: rtl/alu_exec_pkg.sv
// Shared opcodes, ALU select codes, FSM states and flag layout for the
// format-I execute sequencer.
package alu_exec_pkg;

    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_ADDC = 4'd6;
    localparam logic [3:0] OP_SUBC = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_DADD = 4'd10;
    localparam logic [3:0] OP_BIT  = 4'd11;
    localparam logic [3:0] OP_BIC  = 4'd12;
    localparam logic [3:0] OP_BIS  = 4'd13;
    localparam logic [3:0] OP_XOR  = 4'd14;
    localparam logic [3:0] OP_AND  = 4'd15;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_AND = 5'b00011;
    localparam logic [4:0] ALU_XOR = 5'b00100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {ST_IDLE, ST_P1, ST_P2, ST_NIB, ST_DONE} state_t;
    typedef enum logic [1:0] {CLS_ARITH, CLS_AND, CLS_XOR, CLS_NONE} cls_t;

    function automatic cls_t op_class(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADDC, OP_SUBC, OP_SUB, OP_CMP: return CLS_ARITH;
            OP_AND, OP_BIT:                           return CLS_AND;
            OP_XOR:                                   return CLS_XOR;
            default:                                  return CLS_NONE;
        endcase
    endfunction

    function automatic logic op_is_sub(input logic [3:0] op);
        return (op == OP_SUBC) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    function automatic logic msb_of(input logic [15:0] v, input logic byte_mode);
        return byte_mode ? v[7] : v[15];
    endfunction

endpackage

// File: rtl/alu_exec_seq_flag_calc.sv
// Combinational status-flag helper: MSB carry of the current pass plus
// N/Z/V of the final result for the instruction's class.
module alu_flag_calc
    import alu_exec_pkg::*;
(
    input  logic        i_byte_mode,
    input  cls_t        i_cls,
    input  logic        i_pa_msb,
    input  logic        i_pb_msb,
    input  logic        i_pr_msb,
    input  logic        i_pr_c8,
    input  logic        i_dst_msb,
    input  logic        i_bp_msb,
    input  logic [15:0] i_res,
    output logic        o_carry,
    output logic        o_v,
    output logic        o_n,
    output logic        o_z
);

    always_comb begin
        // Byte operands are zero-extended, so bit 8 of the sum is the carry.
        o_carry = i_byte_mode ? i_pr_c8
                              : ((i_pa_msb & i_pb_msb) | ((i_pa_msb ^ i_pb_msb) & ~i_pr_msb));
        o_n     = msb_of(i_res, i_byte_mode);
        o_z     = i_byte_mode ? (i_res[7:0] == 8'h00) : (i_res == 16'h0000);
        case (i_cls)
            CLS_ARITH: o_v = (i_dst_msb == i_bp_msb) && (o_n != i_dst_msb);
            CLS_XOR:   o_v = i_dst_msb & i_bp_msb;
            default:   o_v = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle format-I execute sequencer driving an external 16-bit ALU.
// state | meaning
// IDLE  | waiting for start     P1 | first ALU pass     P2 | carry-in / BIS pass
// NIB   | one DADD nibble/pass  DONE | results presented for one cycle
module alu_exec_seq
    import alu_exec_pkg::*;
#(
    parameter bit DADD_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic        i_byte_mode,
    input  logic [15:0] i_src,
    input  logic [15:0] i_dst,
    input  logic [3:0]  i_sr_in,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_result,
    output logic        o_wb_en,
    output logic [3:0]  o_flags_out,
    output logic        o_flags_we,
    output logic        o_err,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [4:0]  o_alu_sel,
    input  logic [15:0] i_alu_result
);

    state_t      r_state, w_next;
    logic [3:0]  r_op, r_flags;
    logic        r_byte, r_cin, r_srv, r_c, r_dc, r_err;
    logic [15:0] r_dst, r_src, r_res, r_and;
    logic [1:0]  r_k;

    cls_t        w_cls;
    logic [15:0] w_mask, w_in_mask, w_bp, w_res_next;
    logic        w_need_p2, w_last, w_legal, w_dhi;
    logic [4:0]  w_dsum;
    logic [3:0]  w_digit, w_flags_next;
    logic        w_carry, w_v, w_n, w_z;
    logic        w_unused_sr;

    // Incoming N and Z never influence any result.
    assign w_unused_sr = ^i_sr_in[3:2];

    assign w_cls     = op_class(r_op);
    assign w_mask    = r_byte ? 16'h00FF : 16'hFFFF;
    assign w_in_mask = i_byte_mode ? 16'h00FF : 16'hFFFF;
    assign w_bp      = (op_is_sub(r_op) ? ~r_src : r_src) & w_mask;
    assign w_need_p2 = (r_op == OP_BIS) || ((w_cls == CLS_ARITH) && r_cin);
    assign w_legal   = (i_op >= OP_MOV) && (DADD_EN || (i_op != OP_DADD));
    assign w_last    = (r_state == ST_P2) || ((r_state == ST_P1) && !w_need_p2) ||
                       ((r_state == ST_NIB) && (r_k == (r_byte ? 2'd1 : 2'd3)));

    assign w_dsum  = i_alu_result[4:0];
    assign w_dhi   = w_dsum > 5'd9;
    assign w_digit = w_dhi ? 4'(w_dsum - 5'd10) : w_dsum[3:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        o_alu_sel = ALU_ADD;
        o_alu_a   = '0;
        o_alu_b   = '0;
        case (r_state)
            ST_IDLE: if (i_start && w_legal) w_next = (i_op == OP_DADD) ? ST_NIB : ST_P1;
            ST_P1: begin
                w_next  = w_need_p2 ? ST_P2 : ST_DONE;
                o_alu_a = r_dst;
                o_alu_b = r_src;
                case (r_op)
                    OP_MOV:         o_alu_a = '0;
                    OP_AND, OP_BIT: o_alu_sel = ALU_AND;
                    OP_BIC: begin
                        o_alu_sel = ALU_AND;
                        o_alu_b   = ~r_src & w_mask;
                    end
                    OP_XOR, OP_BIS: o_alu_sel = ALU_XOR;
                    default:        o_alu_b = w_bp;
                endcase
            end
            ST_P2: begin
                w_next  = ST_DONE;
                o_alu_a = r_res;
                if (r_op == OP_BIS) begin
                    o_alu_sel = ALU_XOR;
                    o_alu_b   = r_and;
                end else begin
                    o_alu_b = 16'h0001;
                end
            end
            ST_NIB: begin
                w_next  = w_last ? ST_DONE : ST_NIB;
                o_alu_a = {12'h000, r_dst[{r_k, 2'b00} +: 4]};
                o_alu_b = {12'h000, r_src[{r_k, 2'b00} +: 4]} + {15'd0, r_dc};
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_res_next = i_alu_result & w_mask;
        if (r_state == ST_NIB) begin
            w_res_next = r_res;
            w_res_next[{r_k, 2'b00} +: 4] = w_digit;
        end
    end

    alu_flag_calc u_flag_calc (
        .i_byte_mode (r_byte),
        .i_cls       (w_cls),
        .i_pa_msb    (msb_of(o_alu_a, r_byte)),
        .i_pb_msb    (msb_of(o_alu_b, r_byte)),
        .i_pr_msb    (i_alu_result[15]),
        .i_pr_c8     (i_alu_result[8]),
        .i_dst_msb   (msb_of(r_dst, r_byte)),
        .i_bp_msb    (msb_of(w_bp, r_byte)),
        .i_res       (w_res_next),
        .o_carry     (w_carry),
        .o_v         (w_v),
        .o_n         (w_n),
        .o_z         (w_z)
    );

    always_comb begin
        w_flags_next         = '0;
        w_flags_next[FLAG_N] = w_n;
        w_flags_next[FLAG_Z] = w_z;
        w_flags_next[FLAG_V] = (r_op == OP_DADD) ? r_srv : w_v;
        case (w_cls)
            CLS_ARITH:        w_flags_next[FLAG_C] = w_carry | ((r_state == ST_P2) & r_c);
            CLS_AND, CLS_XOR: w_flags_next[FLAG_C] = ~w_z;
            default:          w_flags_next[FLAG_C] = w_dhi;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op    <= '0;
            r_byte  <= 1'b0;
            r_dst   <= '0;
            r_src   <= '0;
            r_res   <= '0;
            r_and   <= '0;
            r_cin   <= 1'b0;
            r_srv   <= 1'b0;
            r_c     <= 1'b0;
            r_dc    <= 1'b0;
            r_k     <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_err  <= !w_legal;
                    r_op   <= i_op;
                    r_byte <= i_byte_mode;
                    r_dst  <= i_dst & w_in_mask;
                    r_src  <= i_src & w_in_mask;
                    r_cin  <= (i_op == OP_ADD) ? 1'b0 :
                              ((i_op == OP_ADDC) || (i_op == OP_SUBC)) ? i_sr_in[FLAG_C] : 1'b1;
                    r_dc   <= i_sr_in[FLAG_C];
                    r_srv  <= i_sr_in[FLAG_V];
                    r_k    <= '0;
                    r_res  <= '0;
                    r_c    <= 1'b0;
                end
                ST_P1, ST_P2, ST_NIB: begin
                    r_res <= w_res_next;
                    r_c   <= w_carry | ((r_state == ST_P2) & r_c);
                    if (r_state == ST_NIB) begin
                        r_dc <= w_dhi;
                        r_k  <= r_k + 2'd1;
                    end
                    if (r_state == ST_P1) r_and <= r_dst & r_src;
                    if (w_last) r_flags <= w_flags_next;
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_result    = o_done ? r_res : 16'h0000;
    assign o_flags_out = o_done ? r_flags : 4'h0;
    assign o_wb_en     = o_done && (r_op != OP_CMP) && (r_op != OP_BIT);
    assign o_flags_we  = o_done && ((w_cls != CLS_NONE) || (r_op == OP_DADD));
    assign o_err       = r_err;

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
Multi-cycle execute sequencer for the 16-bit ALU in the MSP430-style core, covering format-I (double-operand) instructions. It accepts one decoded instruction, drives the combinational ALU over one or more passes, and computes the N/Z/C/V status flags itself. It returns the writeback result, writeback enable and flag-update strobe to the register file and status register.

Parameters:
DADD_EN, 1, when 0, DADD reports err like an illegal opcode.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  launch request; sampled only in IDLE
op  in  4  format-I opcode: 4 MOV, 5 ADD, 6 ADDC, 7 SUBC, 8 SUB, 9 CMP, 10 DADD, 11 BIT, 12 BIC, 13 BIS, 14 XOR, 15 AND
byte_mode  in  1  1 = .B operation: operate on low byte only
src  in  16  source operand
dst  in  16  destination operand
sr_in  in  4  current flags {N,Z,C,V}
busy  out  1  high from the cycle after start is accepted through the done cycle
done  out  1  one-cycle completion pulse
result  out  16  final value; upper byte is 0 in byte mode; valid when done=1
wb_en  out  1  with done: write result to dst
flags_out  out  4  new {N,Z,C,V}; valid when done=1
flags_we  out  1  with done: load flags_out into SR
err  out  1  one-cycle pulse for an illegal op (0-3); no done is issued
alu_a, alu_b  out  16  ALU operand drive
alu_sel  out  5  ALU select: ADD 00000, AND 00011, XOR 00100
alu_result  in  16  combinational ALU output for the same cycle

Behaviour:
- Reset values: all outputs 0 and state IDLE. A reset in mid-operation aborts the instruction with no done, no writeback and no flag update.
- Byte mode:
  - Operands are masked to [7:0] before any pass.
  - The pass carry is alu_result[8]; the sign bit is bit 7.
  - Each pass result is masked to 8 bits before reuse.
  - In word mode, carry and sign use bit 15. Pass carry is a&b | (a^b)&~r at the MSB, evaluated on that pass's operands.
- Arithmetic ops (ADD, ADDC, SUB, SUBC, CMP):
  - Operand b' is src for ADD/ADDC and ~src (masked in byte mode) for SUB/SUBC/CMP.
  - Carry-in cin is 0 for ADD, 1 for SUB/CMP, and sr_in.C for ADDC/SUBC.
  - Pass P1 computes ALU ADD(dst, b'). Pass P2 computes ALU ADD(r1, cin) and runs only when cin=1.
  - C is the OR of the pass carries.
  - V = (dst.msb == b'.msb) && (r.msb != dst.msb).
  - N is the result MSB. Z = (r == 0).
- Logic ops:
  - AND and BIT: ALU AND(dst, src).
  - BIC: ALU AND(dst, ~src).
  - XOR: ALU XOR(dst, src).
  - BIS runs two passes: t = XOR(dst, src), then r = XOR(t, AND(dst, src)). The AND result is latched in pass 1, so pass 2 is XOR(t, and_q).
  - MOV: ALU ADD(0, src).
- Flags:
  - AND, BIT and XOR set N and Z, with C = ~Z.
  - V = 0 for AND/BIT. For XOR, V = dst.msb & src.msb.
  - MOV, BIC and BIS set flags_we=0.
  - Every arithmetic op, and DADD, sets flags_we=1.
- Writeback: wb_en=0 for CMP and BIT; wb_en=1 for all other legal ops.
- DADD:
  - Processes one nibble per pass, low to high: 4 passes in word mode, 2 in byte mode.
  - Each pass computes ALU ADD({12'b0, dst_nib}, {12'b0, src_nib} + c), where c starts at sr_in.C.
  - If the pass sum is greater than 9, the digit is sum-10 and c=1; otherwise the digit is sum and c=0.
  - Final C = c, N = MSB, Z = (r == 0), V = sr_in.V (unchanged).
- FSM: IDLE -> P1 -> [P2] -> DONE -> IDLE. DADD runs IDLE -> NIB(k = 0..n-1) -> DONE.
  - The ALU is driven in P1, P2 and NIB; alu_result is registered at the end of each of those cycles.
  - Operands and op are captured on the start cycle, so later input changes are ignored.
  - Latency from start to done = passes + 1 cycles.
  - start is ignored while busy.
  - start may be reasserted in the cycle after done.
  - An illegal op goes IDLE -> IDLE and pulses err in the cycle after start.
  - alu_sel=ADD with alu_a=alu_b=0 whenever the ALU is not being driven.

Decomposition:
- Package alu_exec_pkg holds:
  - the opcode localparams;
  - the ALU select codes (ADD/AND/XOR);
  - the FSM state enum;
  - the flag bit indices {N=3, Z=2, C=1, V=0}.
- Sub-module alu_flag_calc (combinational): from a, b', r, byte_mode and op class, produces the MSB carry, V, N and Z.

Test Plan:
- ADD word: dst=0x7FFF, src=0x0001 -> done 2 cycles after start; result 0x8000, flags N=1 Z=0 C=0 V=1; wb_en=1.
- SUB.B: dst=0x0012, src=0x0034 -> result 0x00DE, N=1 C=0 V=0; 3 cycles; upper byte 0.
- CMP: dst=src=0x1234 -> Z=1 C=1, wb_en=0, flags_we=1. SUBC with sr C=0 instead uses a single pass: done in 2 cycles.
- DADD word: dst=0x0999, src=0x0001, C=0 -> result 0x1000, C=0; done 5 cycles after start. DADD.B: 0x99+0x01 -> 0x00, C=1, Z=1.
- BIS: dst=0x00F0, src=0x0F0F -> result 0x0FFF, flags_we=0, 3 cycles. op=2 -> err pulse, no done.
- rst asserted in the NIB2 cycle -> no done; outputs 0 next cycle; a new ADD started afterwards completes correctly.
